// File: rtl/fir_mc_core.sv
// fir_mc_core: multichannel time-multiplexed FIR, one MAC per cycle, with a
// Wishbone-programmed double-buffered coefficient bank.
module fir_mc_core #(
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int TAPS   = 33,
  parameter  int CH     = 4,
  localparam int CH_W   = CH > 1 ? $clog2(CH) : 1,
  localparam int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic [7:0]        wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              busy
);
  localparam int PW = DATA_W + COEF_W;
  localparam int KW = $clog2(TAPS + 1);
  localparam int IW = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state;
  logic enable, cp, clp, req, coef_ok, bad, ch_ok;
  logic [KW-1:0] k;
  logic [CH_W-1:0] ch;
  logic [IW-1:0] ci;
  logic [15:0] cur, wdat, rd;
  logic signed [OUT_W-1:0] acc;
  logic signed [PW-1:0] prod;
  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [DATA_W-1:0] hist [CH][TAPS];
  assign busy = state != IDLE;
  assign in_ready = state == IDLE && enable && !cp && !clp;
  always_comb begin
    ci = wb_adr_i[IW-1:0];
    coef_ok = wb_adr_i[7:6] == 2'b01 && int'(wb_adr_i[5:0]) < TAPS;
    bad = !(coef_ok || wb_adr_i == 8'h00 || (!wb_we_i && (wb_adr_i == 8'h01 || wb_adr_i == 8'h02)));
    req = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
    ch_ok = int'(in_ch) < CH;
    cur = 16'(shadow[ci]);
    wdat = {wb_sel_i[1] ? wb_dat_i[15:8] : cur[15:8], wb_sel_i[0] ? wb_dat_i[7:0] : cur[7:0]};
    rd = wb_adr_i == 8'h00 ? {15'd0, enable} :
         wb_adr_i == 8'h01 ? {13'd0, clp, cp, busy} :
         wb_adr_i == 8'h02 ? {1'b0, 7'(TAPS), 3'd0, 5'(CH)} : cur;
    prod = active[k[IW-1:0]] * hist[ch][k[IW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      enable <= 1'b0;
      cp <= 1'b0;
      clp <= 1'b0;
      k <= '0;
      ch <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < TAPS; j++) hist[c][j] <= '0;
    end else begin
      wb_ack_o <= req && !bad;
      wb_err_o <= req && bad;
      wb_dat_o <= (req && !bad) ? rd : '0;
      case (state)
        IDLE: begin
          if (cp) for (int i = 0; i < TAPS; i++) active[i] <= shadow[i];
          if (clp) for (int c = 0; c < CH; c++) for (int j = 0; j < TAPS; j++) hist[c][j] <= '0;
          cp <= 1'b0;
          clp <= 1'b0;
          // out-of-range channel tags are consumed without touching any history
          if (in_valid && in_ready && ch_ok) begin
            for (int j = TAPS - 1; j > 0; j--) hist[in_ch][j] <= hist[in_ch][j-1];
            hist[in_ch][0] <= in_data;
            ch <= in_ch;
            acc <= '0;
            k <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == KW'(TAPS)) begin
            out_data <= acc;
            out_ch <= ch;
            out_valid <= 1'b1;
            state <= OUT;
          end else begin
            acc <= acc + {{(OUT_W-PW){prod[PW-1]}}, prod};
            k <= k + 1'b1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (req && !bad && wb_we_i) begin
        if (wb_adr_i == 8'h00 && wb_sel_i[0]) begin
          enable <= wb_dat_i[0];
          if (wb_dat_i[1]) cp <= 1'b1;
          if (wb_dat_i[2]) clp <= 1'b1;
        end
        if (coef_ok) shadow[ci] <= COEF_W'(wdat);
      end
    end
  end
endmodule

// File: doc/fir_mc_core.md
FIR_MC_CORE -- requirements
Module: fir_mc_core

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, input sample width, signed two's complement.
REQ-002 SHALL provide parameter COEF_W, default 16, coefficient width, signed.
REQ-003 SHALL provide parameter TAPS, default 33, filter length, legal range 2..64.
REQ-004 SHALL provide parameter CH, default 4, independent channel count, legal range 1..16; derived CH_W = max(1, clog2(CH)).
REQ-005 SHALL derive OUT_W = DATA_W + COEF_W + clog2(TAPS) as the full-precision output width.
REQ-006 Ports, in order:
- clk  in  1  sole clock; one clock, all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_data  in  DATA_W  sample.
- in_ch  in  CH_W  channel tag.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  OUT_W  filter result.
- out_ch  out  CH_W  channel tag of the result.
- wb_adr_i  in  8  Wishbone address.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  2  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- busy  out  1  high outside IDLE.

Function
REQ-007 Register map:
- 0x00 CTRL: bit0 enable (RW), bit1 commit (W1, self-clearing), bit2 clear (W1, self-clearing).
- 0x01 STATUS (RO): bit0 busy, bit1 commit_pending, bit2 clear_pending.
- 0x02 CH_CFG (RO): CH in [4:0], TAPS in [14:8].
- 0x40+k for k < TAPS: shadow coefficient k (RW).
REQ-008 Wishbone: when wb_cyc_i & wb_stb_i and no ack/err is pending, exactly one of wb_ack_o/wb_err_o SHALL pulse for one cycle on the next edge; no response occurs in the cycle after a response.
REQ-009 Any access to an address not in REQ-007, a write to 0x01/0x02, or an access to 0x40+k with k >= TAPS SHALL give wb_err_o and no register change.
REQ-010 Writes SHALL honour wb_sel_i per byte; a CTRL write with wb_sel_i[0]=0 SHALL not trigger commit or clear; wb_dat_o SHALL be valid while ack is high and 0 otherwise.
REQ-011 Coefficients SHALL be double-buffered: the MAC uses only the active bank; writes go to the shadow bank.
REQ-012 commit SHALL set commit_pending; the shadow-to-active copy SHALL occur in one cycle while in IDLE, never during MAC or OUT.
REQ-013 clear SHALL set clear_pending; all channels' history SHALL be zeroed in one cycle while in IDLE.
REQ-014 When commit and clear are both pending in IDLE, both SHALL execute in the same cycle.
REQ-015 FSM states:
- IDLE: in_ready = enable & !commit_pending & !clear_pending.
- On a handshake in IDLE, the sample SHALL be shifted into history[in_ch] (newest at index 0), the tag latched, the accumulator zeroed, and the FSM SHALL go to MAC.
- MAC: one signed product active[k]*history[ch][k] added per cycle, k = 0..TAPS-1, then OUT.
- OUT: out_valid=1 and out_data/out_ch SHALL be held stable until out_ready; then IDLE.
REQ-016 Latency: out_valid SHALL rise exactly TAPS+1 edges after the accepting edge; in_ready SHALL be 0 in MAC and OUT.
REQ-017 Accumulation SHALL be signed, OUT_W wide, with no saturation or rounding; no overflow is possible by construction.
REQ-018 Channels SHALL be independent; a sample on channel c SHALL not alter the history of any other channel.
REQ-019 In_ch >= CH SHALL be accepted and discarded, with no history change and no output.
REQ-020 Clearing enable SHALL not abort a computation in progress; it only blocks new acceptance.

Reset
REQ-021 Asserting rst_n low SHALL immediately force IDLE and:
- in_ready=0, out_valid=0, out_data=0, out_ch=0, wb_ack_o=0, wb_err_o=0, busy=0, wb_dat_o=0.
- enable=0, pending flags=0.
- all history = 0; shadow and active coefficients = 0.
REQ-022 Reset asserted mid-MAC or mid-OUT SHALL discard the result with no out_valid after release; Wishbone access SHALL be possible on the first edge after release.

Verification
REQ-023 Impulse test (TAPS=33, CH=4): write coef k = k+1, commit, enable, then drive on ch0 the samples 1 followed by 34 zeros -> outputs are 1,2,...,33,0,0; each out_valid appears 34 edges after acceptance.
REQ-024 Commit while busy: write new shadow set and commit during MAC -> the in-flight result uses the old set, commit_pending reads 1, in_ready stays 0 until the copy completes, and the next sample uses the new set.
REQ-025 Isolation and backpressure: interleave ch0 = +100 and ch3 = -5 with all coef = 1 and out_ready low for 10 cycles -> out_data/out_ch held stable; after the 33rd sample per channel, ch0 = 3300 and ch3 = -165.
REQ-026 Bus errors: read 0x03, write 0x01, read 0x40+33 -> wb_err_o pulses once each, with no state change; read 0x02 -> 0x2104.
REQ-027 Reset mid-MAC: assert rst_n low at MAC cycle 10 -> all outputs 0 immediately, no out_valid afterwards, and reading coefficient 0x40 returns 0.
